clause_queue: RTL and testbench
===============================

CLAUSE_QUEUE -- requirements
Module: clause_queue

Interface
REQ-001 Parameter DEPTH, default 8: number of clause entries held; power of two, at least 4.
REQ-002 Parameter CLAUSE_WIDTH, default 4: literals per clause.
REQ-003 Parameter ELEMENT_BIT_CNT, default 11: bits per literal; an all-zero literal is padding.
REQ-004 clock  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-006 grant_in  input  1: push strobe, one bit of the arbiter's grant vector.
REQ-007 clause_in  input  CLAUSE_WIDTH*ELEMENT_BIT_CNT: clause presented with grant_in.
REQ-008 full_out  input-side  output  1: back-pressure to the arbiter; the arbiter receives ~full_out as its request.
REQ-009 clause_out  output  CLAUSE_WIDTH*ELEMENT_BIT_CNT: head clause, first-word-fall-through.
REQ-010 valid_out  output  1: clause_out holds a valid clause.
REQ-011 ready_in  input  1: consumer (BCP engine) accepts the head this cycle.
REQ-012 flush_in  input  1: synchronous discard of all stored clauses.
REQ-013 count_out  output  $clog2(DEPTH)+1: number of stored clauses.
REQ-014 empty_out  output  1: count_out == 0.
REQ-015 overflow_err  output  1: sticky flag, set when a push is dropped for lack of space.

Function
REQ-016 push_req = grant_in, AND-ed with the condition that at least one literal of clause_in is non-zero; a grant carrying an all-zero clause SHALL be ignored.
REQ-017 pop = valid_out & ready_in.
REQ-018 Push accepted when count < DEPTH, or when count == DEPTH and pop is asserted in the same cycle.
REQ-019 An accepted push writes clause_in at the write pointer and advances it, wrapping modulo DEPTH.
REQ-020 A pop advances the read pointer, wrapping modulo DEPTH.
REQ-021 count next-state:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop, or neither.
REQ-022 Simultaneous push and pop at count == 0 SHALL NOT occur, because valid_out = 0 there; the push alone is accepted.
REQ-023 full_out = (count >= DEPTH-1), driven from registered count (one slot of slack for the arbiter's registered grant).
REQ-024 valid_out = (count != 0); clause_out = mem[rd_ptr] when valid_out, else all zeros.
REQ-025 Latency: a clause pushed in cycle N appears on clause_out with valid_out = 1 in cycle N+1 when the queue was empty.
REQ-026 Output order SHALL be strict FIFO.
REQ-027 Overflow: push_req with count == DEPTH and no pop:
  - clause dropped;
  - pointers and count unchanged;
  - overflow_err = 1 next cycle, held until reset.
REQ-028 flush_in = 1 has priority over push and pop in the same cycle:
  - next cycle: pointers = 0, count = 0, valid_out = 0;
  - any same-cycle push and pop are discarded;
  - overflow_err is unaffected.
REQ-029 Storage contents are not reset; only pointers, count and overflow_err are reset.

Reset
REQ-030 While reset == 0 at a rising edge, next cycle:
  - count_out = 0, empty_out = 1, valid_out = 0, full_out = 0, overflow_err = 0, clause_out = 0;
  - rd_ptr = wr_ptr = 0.
REQ-031 Reset has priority over flush_in, grant_in and ready_in.
REQ-032 Reset asserted mid-operation discards all stored clauses.

Verification
REQ-033 Reset: reset = 0 for 2 cycles with grant_in = 1 and a non-zero clause -> count_out 0, valid_out 0, full_out 0, empty_out 1, overflow_err 0.
REQ-034 Fill (DEPTH = 8, ready_in = 0):
  - 7 pushes of distinct clauses -> count_out 7, full_out 1 in the cycle after the 7th push;
  - 8th push -> count_out 8;
  - 9th push -> dropped, count_out stays 8, overflow_err 1.
REQ-035 Ordering: push 0x001, 0x002, 0x003 in the low literal, then ready_in = 1 -> clause_out 0x001, 0x002, 0x003 in consecutive cycles, then valid_out 0, empty_out 1.
REQ-036 Full push+pop: at count 8, grant_in = 1 and ready_in = 1 together -> count_out stays 8, overflow_err stays 0, new clause emerges last.
REQ-037 Flush: count 5, then flush_in = 1 with grant_in = 1 and ready_in = 1 in the same cycle -> count_out 0, valid_out 0 next cycle; a subsequent push appears after 1 cycle.
REQ-038 Padding and wrap:
  - grant_in = 1 with clause_in = 0 -> count_out unchanged;
  - 20 push/pop pairs across pointer wrap -> data intact, in order.

Source files
------------

// File: rtl/clause_queue_if.sv
// Clause queue bus: push side (arbiter grant + clause), pop side (head clause
// to the BCP engine), flush, and status.
//
// Handshake: the pop side is valid/ready. The queue asserts valid_out whenever
// it holds a clause, and clause_out stays stable until it is taken. A clause
// leaves the queue on the rising edge where valid_out && ready_in. The push
// side is a strobe: a grant_in carrying a non-zero clause is a push request.
// Any push the queue cannot take is dropped and recorded in overflow_err.
// full_out warns one entry early because the arbiter's grant is registered.
interface clause_queue_if #(
    parameter int DEPTH           = 8,
    parameter int CLAUSE_WIDTH    = 4,
    parameter int ELEMENT_BIT_CNT = 11
);
    localparam int CLAUSE_BITS = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
    localparam int CNT_W       = $clog2(DEPTH) + 1;

    logic                   grant_in;
    logic [CLAUSE_BITS-1:0] clause_in;
    logic                   full_out;
    logic [CLAUSE_BITS-1:0] clause_out;
    logic                   valid_out;
    logic                   ready_in;
    logic                   flush_in;
    logic [CNT_W-1:0]       count_out;
    logic                   empty_out;
    logic                   overflow_err;

    // Producer/consumer side (arbiter, BCP engine, test driver).
    modport master (
        output grant_in, clause_in, ready_in, flush_in,
        input  full_out, clause_out, valid_out, count_out, empty_out, overflow_err
    );

    // Queue side.
    modport slave (
        input  grant_in, clause_in, ready_in, flush_in,
        output full_out, clause_out, valid_out, count_out, empty_out, overflow_err
    );
endinterface

// File: rtl/clause_queue.sv
// Clause queue: first-word-fall-through FIFO of SAT clauses between the
// clause arbiter and the BCP engine. All-zero clauses are treated as padding
// and never stored. Storage is not reset; only the pointers, the count and
// the sticky overflow flag are reset.
module clause_queue #(
    parameter int DEPTH           = 8,
    parameter int CLAUSE_WIDTH    = 4,
    parameter int ELEMENT_BIT_CNT = 11
) (
    input  logic          clock,
    input  logic          reset,
    clause_queue_if.slave bus
);
    localparam int CLAUSE_BITS = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_NEARLY  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    logic [CLAUSE_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic                   overflow;

    logic push_req;
    logic pop;
    logic push_ok;
    logic drop;
    logic valid;

    // Request decode: padding clauses never count as a push; a full queue can
    // still accept a push when the head leaves in the same cycle.
    always_comb begin
        valid    = (count != '0);
        push_req = bus.grant_in && (|bus.clause_in);
        pop      = valid && bus.ready_in;
        push_ok  = push_req && ((count != CNT_FULL) || pop);
        drop     = push_req && (count == CNT_FULL) && !pop;
    end

    // Clause storage: written only for accepted pushes that survive reset/flush.
    always_ff @(posedge clock) begin
        if (reset && !bus.flush_in && push_ok) begin
            mem[wr_ptr] <= bus.clause_in;
        end
    end

    // Pointer and occupancy bookkeeping; reset beats flush beats push/pop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Sticky overflow flag: only reset clears it; flush leaves it alone.
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (!bus.flush_in && drop) begin
            overflow <= 1'b1;
        end
    end

    // Status and head outputs, all derived from registered state.
    always_comb begin
        bus.full_out     = (count >= CNT_NEARLY);
        bus.valid_out    = valid;
        bus.empty_out    = !valid;
        bus.count_out    = count;
        bus.overflow_err = overflow;
        bus.clause_out   = valid ? mem[rd_ptr] : '0;
    end
endmodule

// File: tb/tb_clause_queue.sv
// Directed bench for clause_queue: reset, fill/overflow, ordering, full
// push+pop, flush, padding and pointer wrap.
module tb_clause_queue;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int EB    = 11;
    localparam int BITS  = CW * EB;

    logic clock;
    logic reset;

    clause_queue_if #(.DEPTH(DEPTH), .CLAUSE_WIDTH(CW), .ELEMENT_BIT_CNT(EB)) bus ();

    clause_queue #(.DEPTH(DEPTH), .CLAUSE_WIDTH(CW), .ELEMENT_BIT_CNT(EB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks;
    int errors;
    logic [BITS-1:0] exp_q[$];

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.grant_in  = 1'b0;
        bus.clause_in = '0;
        bus.ready_in  = 1'b0;
        bus.flush_in  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset         = 1'b0;
        bus.grant_in  = 1'b1;
        bus.clause_in = BITS'(44'h123);
        step();
        step();
        reset = 1'b1;
        idle();
        exp_q.delete();
    endtask

    task automatic push(input logic [BITS-1:0] c);
        bus.grant_in  = 1'b1;
        bus.clause_in = c;
        bus.ready_in  = 1'b0;
        step();
        bus.grant_in  = 1'b0;
        bus.clause_in = '0;
        exp_q.push_back(c);
    endtask

    // Scoreboard: compare the current head with the oldest expected clause,
    // then pop it on the next edge.
    task automatic pop_check(input string tag);
        logic [BITS-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_valid"}, 64'(bus.valid_out), 64'd1);
        check({tag, "_data"}, 64'(bus.clause_out), 64'(e));
        bus.ready_in = 1'b1;
        step();
        bus.ready_in = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        reset = 1'b0;

        // Reset held two cycles with a live grant.
        do_reset();
        check("rst_count", 64'(bus.count_out), 64'd0);
        check("rst_valid", 64'(bus.valid_out), 64'd0);
        check("rst_full", 64'(bus.full_out), 64'd0);
        check("rst_empty", 64'(bus.empty_out), 64'd1);
        check("rst_ovf", 64'(bus.overflow_err), 64'd0);
        check("rst_data", 64'(bus.clause_out), 64'd0);

        // Fill to capacity with ready_in low, then overflow.
        for (int i = 1; i <= 6; i++) push(BITS'(44'h100 + i));
        check("fill6_full", 64'(bus.full_out), 64'd0);
        push(BITS'(44'h107));
        check("fill7_count", 64'(bus.count_out), 64'd7);
        check("fill7_full", 64'(bus.full_out), 64'd1);
        push(BITS'(44'h108));
        check("fill8_count", 64'(bus.count_out), 64'd8);
        check("fill8_ovf", 64'(bus.overflow_err), 64'd0);
        push(BITS'(44'h109));
        void'(exp_q.pop_back());
        check("fill9_count", 64'(bus.count_out), 64'd8);
        check("fill9_ovf", 64'(bus.overflow_err), 64'd1);
        check("fill9_head", 64'(bus.clause_out), 64'h101);
        step();
        check("ovf_sticky", 64'(bus.overflow_err), 64'd1);

        // Reset mid-operation discards contents and clears the flag.
        do_reset();
        check("rst2_count", 64'(bus.count_out), 64'd0);
        check("rst2_ovf", 64'(bus.overflow_err), 64'd0);

        // Ordering with one-cycle fall-through latency.
        push(BITS'(44'h001));
        check("lat_valid", 64'(bus.valid_out), 64'd1);
        check("lat_data", 64'(bus.clause_out), 64'h001);
        push(BITS'(44'h002));
        push(BITS'(44'h003));
        pop_check("ord1");
        pop_check("ord2");
        pop_check("ord3");
        check("ord_valid", 64'(bus.valid_out), 64'd0);
        check("ord_empty", 64'(bus.empty_out), 64'd1);
        check("ord_data0", 64'(bus.clause_out), 64'd0);

        // Full queue with simultaneous push and pop.
        for (int i = 0; i < 8; i++) push(BITS'(44'h010 + i));
        check("fpp_pre", 64'(bus.count_out), 64'd8);
        bus.grant_in  = 1'b1;
        bus.clause_in = BITS'(44'h099);
        bus.ready_in  = 1'b1;
        step();
        idle();
        void'(exp_q.pop_front());
        exp_q.push_back(BITS'(44'h099));
        check("fpp_count", 64'(bus.count_out), 64'd8);
        check("fpp_ovf", 64'(bus.overflow_err), 64'd0);
        for (int i = 0; i < 8; i++) pop_check("fpp_drain");
        check("fpp_empty", 64'(bus.empty_out), 64'd1);

        // Flush beats same-cycle push and pop.
        for (int i = 1; i <= 5; i++) push(BITS'(44'h020 + i));
        check("fl_pre", 64'(bus.count_out), 64'd5);
        bus.flush_in  = 1'b1;
        bus.grant_in  = 1'b1;
        bus.clause_in = BITS'(44'h077);
        bus.ready_in  = 1'b1;
        step();
        idle();
        exp_q.delete();
        check("fl_count", 64'(bus.count_out), 64'd0);
        check("fl_valid", 64'(bus.valid_out), 64'd0);
        check("fl_ovf", 64'(bus.overflow_err), 64'd0);
        push(BITS'(44'h030));
        check("fl_post_count", 64'(bus.count_out), 64'd1);
        pop_check("fl_post");
        check("fl_post_empty", 64'(bus.empty_out), 64'd1);

        // Padding clause ignored, on empty and non-empty queue.
        bus.grant_in  = 1'b1;
        bus.clause_in = '0;
        step();
        idle();
        check("pad_empty", 64'(bus.count_out), 64'd0);
        push(BITS'(44'h040));
        bus.grant_in  = 1'b1;
        bus.clause_in = '0;
        step();
        idle();
        check("pad_count", 64'(bus.count_out), 64'd1);

        // 20 push/pop pairs across pointer wrap; top literal used too.
        for (int k = 0; k < 20; k++) begin
            logic [BITS-1:0] c;
            c = {11'(k + 1), 11'h0, 11'h0, 11'(k + 3)};
            check("wrap_data", 64'(bus.clause_out), 64'(exp_q[0]));
            void'(exp_q.pop_front());
            exp_q.push_back(c);
            bus.grant_in  = 1'b1;
            bus.clause_in = c;
            bus.ready_in  = 1'b1;
            step();
            idle();
            check("wrap_count", 64'(bus.count_out), 64'd1);
        end
        pop_check("wrap_last");
        check("wrap_empty", 64'(bus.empty_out), 64'd1);
        check("end_ovf", 64'(bus.overflow_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
